fl_dma_tx_arbiter: RTL and testbench
====================================

// Module: fl_dma_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing the single HW->SW DMA transmit channel (drained by
//  c_receiveData) among INPUTS FrameLink sources (output drivers/monitors of the DUT).
//  Grants the channel frame-atomically and prepends a one-word routing header carrying
//  the source index so the SW side can demultiplex. Sits between verification output
//  endpoints and the DMA TX buffer; software gates it via ENABLE.
// PARAMETERS
//  DATA_WIDTH  64    FrameLink data width in bits (multiple of 8, >=16)
//  INPUTS      4     number of requesting FrameLink sources (2..16)
//  HDR_TAG     8'hA5 constant placed in header bits [15:8]
// PORTS
//  CLK            in   1                      clock
//  RESET          in   1                      synchronous reset, active high
//  ENABLE         in   1                      1 = new grants allowed
//  RX_DATA        in   INPUTS*DATA_WIDTH      input i at [i*DW +: DW]
//  RX_REM         in   INPUTS*log2(DW/8)      valid-bytes remainder per input
//  RX_SOF_N       in   INPUTS                 start of frame, active low
//  RX_EOF_N       in   INPUTS                 end of frame
//  RX_SOP_N       in   INPUTS                 start of part
//  RX_EOP_N       in   INPUTS                 end of part
//  RX_SRC_RDY_N   in   INPUTS                 source ready
//  RX_DST_RDY_N   out  INPUTS                 destination ready to each source
//  TX_DATA        out  DATA_WIDTH             to DMA TX buffer
//  TX_REM         out  log2(DW/8)
//  TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N     out 1 each
//  TX_SRC_RDY_N   out  1
//  TX_DST_RDY_N   in   1
//  BUSY           out  1                      1 while in HDR or DATA state
//  ACTIVE_ID      out  log2(INPUTS)           index of current/last grant
//  FRAME_CNT      out  32                     frames completed on TX
// BEHAVIOUR
//  Reset: state IDLE, RX_DST_RDY_N all 1, TX_SRC_RDY_N=1, TX_*_N=1, TX_DATA=0,
//   BUSY=0, ACTIVE_ID=0, FRAME_CNT=0, rr pointer=INPUTS-1 (input 0 wins first).
//  FSM IDLE -> HDR -> DATA -> IDLE.
//  IDLE: request_i = !RX_SRC_RDY_N[i] & !RX_SOF_N[i]. If ENABLE & any request: grant
//   first requester searching from ptr+1 modulo INPUTS; latch ACTIVE_ID, ptr<=grant,
//   go HDR next cycle. Inputs not at SOF are never granted (held, DST_RDY_N=1).
//  HDR: TX_DATA = {zero, HDR_TAG, zext(ACTIVE_ID) in [7:0]}, TX_REM all ones,
//   TX_SOF_N=0, TX_SOP_N=0, TX_EOP_N=0, TX_EOF_N=1, TX_SRC_RDY_N=0. Held stable
//   until TX_DST_RDY_N=0, then DATA. All RX_DST_RDY_N remain 1 in HDR.
//  DATA: combinational pass-through of granted input: TX_DATA/REM/SOP_N/EOP_N/EOF_N
//   and SRC_RDY_N from input g; TX_SOF_N forced 1. RX_DST_RDY_N[g]=TX_DST_RDY_N,
//   all others 1. Transfer word = !TX_SRC_RDY_N & !TX_DST_RDY_N. Transfer with
//   EOF_N=0 -> FRAME_CNT+1 (wraps 2^32-1 -> 0), go IDLE.
//  Latency: grant decision to header valid = 1 cycle; min 1 IDLE cycle between frames,
//   so back-to-back frames cost 2 overhead cycles (IDLE+HDR).
//  Single-word frame (SOF&EOF same word): HDR then one DATA word, then IDLE.
//  ENABLE=0 in HDR/DATA: current frame completes unaltered; no further grant.
//  Input asserting SOF_N=0 again mid-frame: passed through unchanged (source error,
//   not corrected); frame ends only on EOF.
//  Reset mid-frame: returns to reset state next cycle; partial frame abandoned,
//   FRAME_CNT not incremented.
//  No combinational path RX_SRC_RDY_N -> RX_DST_RDY_N; only TX_DST_RDY_N ->
//   RX_DST_RDY_N in DATA.
// TESTING
//  1. Input 2 sends 3-word frame D0..D2, TX always ready -> TX: hdr 0x..A502,
//     D0..D2 with SOF_N=1, EOF_N=0 on D2; FRAME_CNT=1; BUSY high 4 cycles.
//  2. Inputs 0,1,3 request together, repeat 6 frames -> grant order 0,1,3,0,1,3.
//  3. TX_DST_RDY_N=1 for 5 cycles in HDR -> header word held stable, all RX_DST_RDY_N=1.
//  4. ENABLE drops on 2nd word of 4-word frame -> frame completes, no new grant while 0.
//  5. RESET on 2nd data word -> next cycle TX_SRC_RDY_N=1, FRAME_CNT=0, input 0 wins next.
//  6. Force FRAME_CNT=32'hFFFFFFFF, send 1-word frame -> FRAME_CNT=0.

Source files
------------

// File: rtl/fl_dma_tx_arbiter.sv
// fl_dma_tx_arbiter
// Round-robin, frame-atomic scheduler that shares one FrameLink DMA TX channel
// among INPUTS sources. Each granted frame is preceded by a one-word routing
// header {HDR_TAG, source index} so software can demultiplex the stream.
module fl_dma_tx_arbiter #(
   parameter int          DATA_WIDTH = 64,
   parameter int          INPUTS     = 4,
   parameter logic [7:0]  HDR_TAG    = 8'hA5,
   localparam int         RW         = $clog2(DATA_WIDTH / 8),
   localparam int         IW         = $clog2(INPUTS)
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         ENABLE,
   input  logic [INPUTS*DATA_WIDTH-1:0] RX_DATA,
   input  logic [INPUTS*RW-1:0]         RX_REM,
   input  logic [INPUTS-1:0]            RX_SOF_N,
   input  logic [INPUTS-1:0]            RX_EOF_N,
   input  logic [INPUTS-1:0]            RX_SOP_N,
   input  logic [INPUTS-1:0]            RX_EOP_N,
   input  logic [INPUTS-1:0]            RX_SRC_RDY_N,
   output logic [INPUTS-1:0]            RX_DST_RDY_N,
   output logic [DATA_WIDTH-1:0]        TX_DATA,
   output logic [RW-1:0]                TX_REM,
   output logic                         TX_SOF_N,
   output logic                         TX_EOF_N,
   output logic                         TX_SOP_N,
   output logic                         TX_EOP_N,
   output logic                         TX_SRC_RDY_N,
   input  logic                         TX_DST_RDY_N,
   output logic                         BUSY,
   output logic [IW-1:0]                ACTIVE_ID,
   output logic [31:0]                  FRAME_CNT
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         id_q, id_d;
   logic [31:0]           frame_cnt_q, frame_cnt_d;
   logic                  busy_q, busy_d;

   logic [INPUTS-1:0]     req_s;
   logic                  found_s;
   logic [IW-1:0]         grant_s;
   logic [IW:0]           sum_s;
   logic [IW-1:0]         idx_s;

   logic [DATA_WIDTH-1:0] g_data_s;
   logic [RW-1:0]         g_rem_s;
   logic                  g_eof_n_s;
   logic                  g_sop_n_s;
   logic                  g_eop_n_s;
   logic                  g_src_rdy_n_s;
   logic                  xfer_s;

   // Round-robin search: first input at SOF starting just after the last grant
   always_comb begin
      req_s   = ~RX_SRC_RDY_N & ~RX_SOF_N;
      found_s = 1'b0;
      grant_s = '0;
      sum_s   = '0;
      idx_s   = '0;
      for (int k = 1; k <= INPUTS; k++) begin
         sum_s = {1'b0, ptr_q} + (IW+1)'(k);
         if (sum_s >= (IW+1)'(INPUTS)) begin
            sum_s = sum_s - (IW+1)'(INPUTS);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[IW-1:0];
         if (!found_s && req_s[idx_s]) begin
            found_s = 1'b1;
            grant_s = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Select the signals of the currently granted input
   always_comb begin
      g_data_s      = '0;
      g_rem_s       = '0;
      g_eof_n_s     = 1'b1;
      g_sop_n_s     = 1'b1;
      g_eop_n_s     = 1'b1;
      g_src_rdy_n_s = 1'b1;
      for (int i = 0; i < INPUTS; i++) begin
         if (id_q == IW'(i)) begin
            g_data_s      = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            g_rem_s       = RX_REM[i*RW +: RW];
            g_eof_n_s     = RX_EOF_N[i];
            g_sop_n_s     = RX_SOP_N[i];
            g_eop_n_s     = RX_EOP_N[i];
            g_src_rdy_n_s = RX_SRC_RDY_N[i];
         end else begin
            g_data_s = g_data_s;
         end
      end
   end

   // TX/RX handshake outputs: idle, header word, or pass-through of the grant
   always_comb begin
      TX_DATA      = '0;
      TX_REM       = '0;
      TX_SOF_N     = 1'b1;
      TX_EOF_N     = 1'b1;
      TX_SOP_N     = 1'b1;
      TX_EOP_N     = 1'b1;
      TX_SRC_RDY_N = 1'b1;
      RX_DST_RDY_N = '1;
      case (state_q)
         S_HDR: begin
            TX_DATA      = {{(DATA_WIDTH-16){1'b0}}, HDR_TAG, 8'(id_q)};
            TX_REM       = '1;
            TX_SOF_N     = 1'b0;
            TX_SOP_N     = 1'b0;
            TX_EOP_N     = 1'b0;
            TX_SRC_RDY_N = 1'b0;
         end
         S_DATA: begin
            TX_DATA      = g_data_s;
            TX_REM       = g_rem_s;
            TX_EOF_N     = g_eof_n_s;
            TX_SOP_N     = g_sop_n_s;
            TX_EOP_N     = g_eop_n_s;
            TX_SRC_RDY_N = g_src_rdy_n_s;
            for (int i = 0; i < INPUTS; i++) begin
               RX_DST_RDY_N[i] = (id_q == IW'(i)) ? TX_DST_RDY_N : 1'b1;
            end
         end
         default: begin
            TX_SRC_RDY_N = 1'b1;
         end
      endcase
   end

   assign xfer_s = !g_src_rdy_n_s && !TX_DST_RDY_N;

   // Next-state logic: grant in IDLE, wait for header accept, run frame to EOF
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (ENABLE && found_s) begin
               state_d = S_HDR;
               id_d    = grant_s;
               ptr_d   = grant_s;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HDR: begin
            if (!TX_DST_RDY_N) begin
               state_d = S_DATA;
            end else begin
               state_d = S_HDR;
            end
         end
         S_DATA: begin
            if (xfer_s && !g_eof_n_s) begin
               state_d     = S_IDLE;
               frame_cnt_d = frame_cnt_q + 32'd1;
            end else begin
               state_d = S_DATA;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State registers with synchronous reset; pointer starts so input 0 wins first
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         ptr_q       <= IW'(INPUTS - 1);
         id_q        <= '0;
         frame_cnt_q <= 32'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         frame_cnt_q <= frame_cnt_d;
         busy_q      <= busy_d;
      end
   end

   assign BUSY      = busy_q;
   assign ACTIVE_ID = id_q;
   assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_fl_dma_tx_arbiter.sv
// Testbench for fl_dma_tx_arbiter: FrameLink source models feed per-input
// queues, expected TX words are queued when frames are created and compared
// against every accepted TX word.
module tb_fl_dma_tx_arbiter;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  rem;
      logic        sof;
      logic        eof;
      logic        sop;
      logic        eop;
   } word_t;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         ENABLE;
   logic [255:0] RX_DATA;
   logic [11:0]  RX_REM;
   logic [3:0]   RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N;
   logic [3:0]   RX_DST_RDY_N;
   logic [63:0]  TX_DATA;
   logic [2:0]   TX_REM;
   logic         TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N;
   logic         TX_DST_RDY_N;
   logic         BUSY;
   logic [1:0]   ACTIVE_ID;
   logic [31:0]  FRAME_CNT;

   word_t src_q[4][$];
   word_t exp_q[$];
   word_t pend_q[$];
   int    checks = 0;
   int    errors = 0;
   int    xfer_cnt = 0;

   fl_dma_tx_arbiter #(.DATA_WIDTH(64), .INPUTS(4), .HDR_TAG(8'hA5)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .RX_DATA(RX_DATA), .RX_REM(RX_REM),
      .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N), .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
      .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
      .TX_DATA(TX_DATA), .TX_REM(TX_REM),
      .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N), .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
      .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
      .BUSY(BUSY), .ACTIVE_ID(ACTIVE_ID), .FRAME_CNT(FRAME_CNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [63:0] hdr_word(input int src);
      return {48'h0, 8'hA5, 8'(src)};
   endfunction

   // drive each source from the head of its queue
   task automatic present();
      word_t w;
      for (int i = 0; i < 4; i++) begin
         if (src_q[i].size() > 0) begin
            w = src_q[i][0];
            RX_DATA[i*64 +: 64] = w.data;
            RX_REM[i*3 +: 3]    = w.rem;
            RX_SOF_N[i]         = w.sof;
            RX_EOF_N[i]         = w.eof;
            RX_SOP_N[i]         = w.sop;
            RX_EOP_N[i]         = w.eop;
            RX_SRC_RDY_N[i]     = 1'b0;
         end else begin
            RX_DATA[i*64 +: 64] = 64'h0;
            RX_REM[i*3 +: 3]    = 3'd0;
            RX_SOF_N[i]         = 1'b1;
            RX_EOF_N[i]         = 1'b1;
            RX_SOP_N[i]         = 1'b1;
            RX_EOP_N[i]         = 1'b1;
            RX_SRC_RDY_N[i]     = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic flush_all();
      for (int i = 0; i < 4; i++) src_q[i].delete();
      exp_q.delete();
      pend_q.delete();
      present();
   endtask

   // build an n-word frame for input src; expected words go to exp_q or pend_q
   task automatic make_frame(input int src, input int n, input bit defer);
      word_t w;
      word_t e;
      e.data = hdr_word(src); e.rem = 3'd7;
      e.sof = 1'b0; e.eof = 1'b1; e.sop = 1'b0; e.eop = 1'b0;
      if (defer) pend_q.push_back(e); else exp_q.push_back(e);
      for (int k = 0; k < n; k++) begin
         w.data = {8'(src), 8'(k), 16'hC0DE, 32'($urandom)};
         w.rem  = (k == n - 1) ? 3'($urandom_range(0, 7)) : 3'd7;
         w.sof  = (k != 0);
         w.eof  = (k != n - 1);
         w.sop  = (k != 0);
         w.eop  = (k != n - 1);
         src_q[src].push_back(w);
         e = w;
         e.sof = 1'b1;
         if (defer) pend_q.push_back(e); else exp_q.push_back(e);
      end
      present();
   endtask

   task automatic wait_drain(input string name);
      bit busy_src;
      for (int c = 0; c < 300; c++) begin
         busy_src = 1'b0;
         for (int i = 0; i < 4; i++) if (src_q[i].size() > 0) busy_src = 1'b1;
         if (exp_q.size() == 0 && !busy_src) break;
         tick();
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL %s_drain: %0d expected words left, required 0", name, exp_q.size());
      end
   endtask

   task automatic wait_xfer(input int target, input string name);
      for (int c = 0; c < 200; c++) begin
         if (xfer_cnt >= target) break;
         tick();
      end
      checks++;
      if (xfer_cnt < target) begin
         errors++;
         $display("FAIL %s_wait: transfers %0d, required %0d", name, xfer_cnt, target);
      end
   endtask

   task automatic apply_reset();
      RESET = 1'b1;
      ENABLE = 1'b1;
      TX_DST_RDY_N = 1'b0;
      flush_all();
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // scoreboard monitor: compare every accepted TX word, retire source words
   initial begin
      word_t e;
      word_t a;
      logic [3:0] hs;
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 4; i++) hs[i] = !RX_SRC_RDY_N[i] && !RX_DST_RDY_N[i];
         if (!RESET && !TX_SRC_RDY_N && !TX_DST_RDY_N) begin
            xfer_cnt++;
            checks++;
            a = {TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tx: got %h, required no transfer", a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL tx_word: got %h, required %h", a, e);
               end
            end
         end
         @(posedge CLK);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
         present();
      end
   end

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, RX_DST_RDY_N, BUSY, ACTIVE_ID, FRAME_CNT, TX_DATA} !==
          {1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 32'd0, 64'h0}) begin
         errors++;
         $display("FAIL reset_state: src_rdy_n=%b sof_n=%b eof_n=%b dst_rdy_n=%h busy=%b id=%0d cnt=%0d data=%h, required 1 1 1 f 0 0 0 0",
                  TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, RX_DST_RDY_N, BUSY, ACTIVE_ID, FRAME_CNT, TX_DATA);
      end
   endtask

   task automatic test_single_frame();
      int busy_cycles = 0;
      apply_reset();
      make_frame(2, 3, 1'b0);
      for (int c = 0; c < 20; c++) begin
         tick();
         if (BUSY) busy_cycles++;
      end
      checks++;
      if (busy_cycles != 4) begin
         errors++;
         $display("FAIL busy_cycles: got %0d, required 4", busy_cycles);
      end
      wait_drain("single");
      checks++;
      if (FRAME_CNT !== 32'd1 || ACTIVE_ID !== 2'd2) begin
         errors++;
         $display("FAIL single_cnt: cnt=%0d id=%0d, required cnt=1 id=2", FRAME_CNT, ACTIVE_ID);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         make_frame(0, 2 + r, 1'b0);
         make_frame(1, 2 + r, 1'b0);
         make_frame(3, 2 + r, 1'b0);
      end
      wait_drain("rr");
      checks++;
      if (FRAME_CNT !== 32'd6 || ACTIVE_ID !== 2'd3) begin
         errors++;
         $display("FAIL rr_cnt: cnt=%0d id=%0d, required cnt=6 id=3", FRAME_CNT, ACTIVE_ID);
      end
   endtask

   task automatic test_hdr_stall();
      apply_reset();
      TX_DST_RDY_N = 1'b1;
      make_frame(2, 2, 1'b0);
      for (int c = 0; c < 20; c++) begin
         if (!TX_SRC_RDY_N) break;
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({TX_DATA, TX_SOF_N, TX_SRC_RDY_N, RX_DST_RDY_N} !== {hdr_word(2), 1'b0, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL hdr_stall: data=%h sof_n=%b src_rdy_n=%b dst_rdy_n=%h, required %h 0 0 f",
                     TX_DATA, TX_SOF_N, TX_SRC_RDY_N, RX_DST_RDY_N, hdr_word(2));
         end
         tick();
      end
      TX_DST_RDY_N = 1'b0;
      wait_drain("stall");
   endtask

   task automatic test_enable_drop();
      int base;
      apply_reset();
      make_frame(1, 4, 1'b0);
      make_frame(3, 2, 1'b1);
      base = xfer_cnt;
      wait_xfer(base + 2, "en_word2");
      ENABLE = 1'b0;
      wait_xfer(base + 5, "en_frame");
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (BUSY !== 1'b0 || TX_SRC_RDY_N !== 1'b1 || RX_DST_RDY_N[3] !== 1'b1) begin
            errors++;
            $display("FAIL en_hold: busy=%b src_rdy_n=%b dst_rdy_n3=%b, required 0 1 1",
                     BUSY, TX_SRC_RDY_N, RX_DST_RDY_N[3]);
         end
      end
      checks++;
      if (FRAME_CNT !== 32'd1 || ACTIVE_ID !== 2'd1) begin
         errors++;
         $display("FAIL en_cnt: cnt=%0d id=%0d, required cnt=1 id=1", FRAME_CNT, ACTIVE_ID);
      end
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      ENABLE = 1'b1;
      wait_drain("en_resume");
      checks++;
      if (FRAME_CNT !== 32'd2 || ACTIVE_ID !== 2'd3) begin
         errors++;
         $display("FAIL en_resume_cnt: cnt=%0d id=%0d, required cnt=2 id=3", FRAME_CNT, ACTIVE_ID);
      end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      apply_reset();
      make_frame(3, 1, 1'b0);
      wait_drain("mid_pre");
      make_frame(1, 4, 1'b0);
      base = xfer_cnt;
      wait_xfer(base + 2, "mid_word2");
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      flush_all();
      checks++;
      if ({TX_SRC_RDY_N, FRAME_CNT, BUSY, RX_DST_RDY_N, TX_DATA} !== {1'b1, 32'd0, 1'b0, 4'hF, 64'h0}) begin
         errors++;
         $display("FAIL mid_reset: src_rdy_n=%b cnt=%0d busy=%b dst_rdy_n=%h data=%h, required 1 0 0 f 0",
                  TX_SRC_RDY_N, FRAME_CNT, BUSY, RX_DST_RDY_N, TX_DATA);
      end
      tick();
      make_frame(0, 2, 1'b0);
      make_frame(2, 2, 1'b0);
      wait_drain("mid_after");
      checks++;
      if (FRAME_CNT !== 32'd2) begin
         errors++;
         $display("FAIL mid_after_cnt: got %0d, required 2", FRAME_CNT);
      end
   endtask

   task automatic test_cnt_wrap();
      apply_reset();
      force dut.frame_cnt_q = 32'hFFFF_FFFF;
      tick();
      release dut.frame_cnt_q;
      tick();
      checks++;
      if (FRAME_CNT !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_preload: got %h, required ffffffff", FRAME_CNT);
      end
      make_frame(0, 1, 1'b0);
      wait_drain("wrap");
      checks++;
      if (FRAME_CNT !== 32'd0 || ACTIVE_ID !== 2'd0) begin
         errors++;
         $display("FAIL wrap_cnt: cnt=%h id=%0d, required cnt=0 id=0", FRAME_CNT, ACTIVE_ID);
      end
   endtask

   initial begin
      RESET = 1'b1;
      ENABLE = 1'b1;
      TX_DST_RDY_N = 1'b0;
      RX_DATA = '0;
      RX_REM = '0;
      RX_SOF_N = '1;
      RX_EOF_N = '1;
      RX_SOP_N = '1;
      RX_EOP_N = '1;
      RX_SRC_RDY_N = '1;
      tick();
      test_reset();
      test_single_frame();
      test_round_robin();
      test_hdr_stall();
      test_enable_drop();
      test_reset_mid_frame();
      test_cnt_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
